game_tick_timer: RTL and testbench
==================================

Name: game_tick_timer

Overview:
- Parametrised in-game timebase for the tetris top level. Replaces the ad-hoc counter/seconds logic.
- Provides a free-running sub-second prescaler, a saturating seconds counter and NUM_TICK independent programmable tick channels (gravity drop, input auto-repeat, ...).
- Gating by gameplay mode and a pause input is fully synchronous.
- Outputs feed the processor (counter/seconds inputs) and the VGA controller (sysTime).

Parameters:
- CLK_HZ, 50000000, clock cycles per second; prescaler wraps at CLK_HZ-1.
- CNT_W, 26, prescaler width; must satisfy 2^CNT_W >= CLK_HZ.
- SEC_W, 16, seconds counter width.
- NUM_TICK, 2, number of tick channels (>=1).
- TICK_W, 26, width of each channel's period register.

Ports:
- clock  in  1  system clock (50 MHz board clock).
- reset  in  1  asynchronous, active-high.
- run  in  1  gameplay mode active (screenMode[31:29]==3'b001, decoded by the top level).
- pause  in  1  freeze all counting while high.
- clear  in  1  synchronous clear of all counters, single-cycle strobe.
- tick_period  in  NUM_TICK*TICK_W  channel i period in cycles, at bits [i*TICK_W +: TICK_W]; 0 = channel disabled.
- sub_count  out  CNT_W  prescaler value, 0..CLK_HZ-1.
- seconds  out  SEC_W  elapsed whole seconds.
- sec_pulse  out  1  one-cycle strobe on each seconds increment.
- tick  out  NUM_TICK  one-cycle strobe per channel.
- sat  out  1  seconds counter saturated.

Behaviour:
- Reset (async assert, sync release by the top level): sub_count=0, seconds=0, sec_pulse=0, tick=0, sat=0, all channel counters=0, run_q=0.
- Control priority each cycle, highest first: clear; run rising edge; !run; pause; count.
- clear=1 or run rising edge (run & ~run_q): every counter goes to 0; no strobes that cycle.
- run=0: all counters held at 0; strobes 0.
- pause=1 with run=1: all counters hold their value; strobes 0. Release resumes from the held value with no lost or extra counts.
- Count state, prescaler:
  - sub_count==CLK_HZ-1: sub_count<=0, seconds increments, sec_pulse=1 in the same cycle the increment is registered.
  - Otherwise sub_count increments.
  - Exactly CLK_HZ cycles per second.
- Seconds saturation: at 2^SEC_W-1, seconds holds and sat<=1; no further sec_pulse. sat clears only on reset, clear or a run rising edge.
- Tick channel i, period P:
  - P==0: counter held at 0, tick[i]=0.
  - Otherwise: if cnt>=P-1, then cnt<=0 and tick[i]=1; else cnt increments.
  - First tick occurs P cycles after entering the count state; strobe period is exactly P cycles.
- Period changes take effect immediately.
  - Shrinking below the current count fires on the next counting cycle and restarts from 0. There is no lockup and no wrap through 2^TICK_W.
  - P==1 gives tick[i]=1 on every counting cycle.
- All outputs are registered. Strobes are asserted in the cycle following the qualifying count state, as flop outputs.
- Channels are independent; simultaneous strobes on all channels plus sec_pulse are legal.
- Reset mid-count: all state zeroes immediately. No strobe emitted.

Decomposition:
- Shared package tetris_timing_pkg holds:
  - CLK_HZ_DEFAULT=50000000.
  - Screen-mode code GAMEPLAY_MODE=3'b001.
  - Default gravity period constant GRAVITY_PERIOD_L0=25000000.
- One sub-module, tick_channel (params TICK_W), instantiated NUM_TICK times via generate.
  - Inputs: clock, reset, clr, hold, period.
  - Output: tick.
  - Implements the period/compare logic above.
- Prescaler and seconds logic live in the parent.

Test Plan:
- Basic count: CLK_HZ=10, run=1 from cycle 0 → sec_pulse every 10 cycles; seconds=3 after 30 counting cycles; sub_count sequence 0..9 repeating.
- Pause: pause at sub_count=4, seconds=1 for 7 cycles, then release → values frozen at 4/1; next sec_pulse 6 cycles after release.
- Gating and clear:
  - run low mid-second → all outputs 0 next cycle.
  - run re-raised → counting restarts from 0.
  - clear asserted together with pause → counters 0, clear wins.
- Saturation: SEC_W=3, CLK_HZ=4 → seconds reaches 7 after 28 cycles; sat=1; no sec_pulse afterward; seconds stays 7 for 20 more cycles.
- Tick channels: NUM_TICK=2, P0=5, P1=0.
  - tick[0] strobes every 5 cycles; tick[1] never strobes.
  - Change P0 to 2 while cnt0=3 → tick[0] on the next cycle, then every 2 cycles.
  - P0=1 → continuous strobe.
- Async reset mid-operation: assert reset asynchronously between edges with cnt0=3, seconds=2 → all outputs 0 immediately. After release, first tick[0] at exactly P0 counting cycles.

Source files
------------

// File: rtl/tetris_timing_pkg.sv
// Shared timing constants for the tetris top level.
// Used by the game timebase and the screen-mode decode.
package tetris_timing_pkg;

  localparam int CLK_HZ_DEFAULT = 50000000;
  localparam logic [2:0] GAMEPLAY_MODE = 3'b001;
  localparam int GRAVITY_PERIOD_L0 = 25000000;

  function automatic logic is_gameplay(
    input logic [2:0] mode
  );
    return mode == GAMEPLAY_MODE;
  endfunction

endpackage

// File: rtl/game_tick_timer_if.sv
// Control and timebase bundle between the tetris top
// level and the game tick timer.
interface game_tick_timer_if #(
  parameter int CNT_W    = 26,
  parameter int SEC_W    = 16,
  parameter int NUM_TICK = 2,
  parameter int TICK_W   = 26
);

  logic                       run;
  logic                       pause;
  logic                       clear;
  logic [NUM_TICK*TICK_W-1:0] tick_period;
  logic [CNT_W-1:0]           sub_count;
  logic [SEC_W-1:0]           seconds;
  logic                       sec_pulse;
  logic [NUM_TICK-1:0]        tick;
  logic                       sat;

  modport master (
    output run, pause, clear, tick_period,
    input  sub_count, seconds, sec_pulse, tick, sat
  );

  modport slave (
    input  run, pause, clear, tick_period,
    output sub_count, seconds, sec_pulse, tick, sat
  );

endinterface

// File: rtl/tick_channel.sv
// One programmable tick channel: strobes once every
// period counting cycles, period 0 disables it.
module tick_channel #(
  parameter int TICK_W = 26
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clr,
  input  logic              hold,
  input  logic [TICK_W-1:0] period,
  output logic              tick
);

  logic [TICK_W-1:0] cnt;
  logic              last;

  // >= rather than == so a shrunk period never wraps around
  assign last = cnt >= (period - TICK_W'(1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (clr) begin
        cnt <= '0;
      end else if (hold) begin
        cnt <= cnt;
      end else if (period == '0) begin
        cnt <= '0;
      end else if (last) begin
        cnt  <= '0;
        tick <= 1'b1;
      end else begin
        cnt <= cnt + TICK_W'(1);
      end
    end
  end

endmodule

// File: rtl/game_tick_timer.sv
// In-game timebase: sub-second prescaler, saturating
// seconds counter and NUM_TICK tick channels.
module game_tick_timer
  import tetris_timing_pkg::*;
#(
  parameter int CLK_HZ   = CLK_HZ_DEFAULT,
  parameter int CNT_W    = 26,
  parameter int SEC_W    = 16,
  parameter int NUM_TICK = 2,
  parameter int TICK_W   = 26
) (
  input logic         clock,
  input logic         reset,
  game_tick_timer_if.slave bus
);

  localparam logic [CNT_W-1:0] WRAP =
    CNT_W'(CLK_HZ - 1);
  localparam logic [SEC_W-1:0] SEC_MAX = '1;

  logic                run_q;
  logic                run_rise;
  logic                restart;
  logic [CNT_W-1:0]    sub_count;
  logic [SEC_W-1:0]    seconds;
  logic                sec_pulse;
  logic                sat;
  logic [NUM_TICK-1:0] tick;

  assign run_rise = bus.run & ~run_q;
  // clear, a fresh run and idle mode all zero every counter
  assign restart  = bus.clear | run_rise | ~bus.run;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run_q     <= 1'b0;
      sub_count <= '0;
      seconds   <= '0;
      sec_pulse <= 1'b0;
      sat       <= 1'b0;
    end else begin
      run_q     <= bus.run;
      sec_pulse <= 1'b0;
      if (restart) begin
        sub_count <= '0;
        seconds   <= '0;
        sat       <= 1'b0;
      end else if (!bus.pause) begin
        if (sub_count == WRAP) begin
          sub_count <= '0;
          if (seconds != SEC_MAX) begin
            seconds   <= seconds + SEC_W'(1);
            sec_pulse <= 1'b1;
            sat <= seconds == (SEC_MAX - SEC_W'(1));
          end
        end else begin
          sub_count <= sub_count + CNT_W'(1);
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_TICK; i++) begin : g_ch
    tick_channel #(
      .TICK_W (TICK_W)
    ) u_ch (
      .clock  (clock),
      .reset  (reset),
      .clr    (restart),
      .hold   (bus.pause),
      .period (bus.tick_period[i*TICK_W +: TICK_W]),
      .tick   (tick[i])
    );
  end

  assign bus.sub_count = sub_count;
  assign bus.seconds   = seconds;
  assign bus.sec_pulse = sec_pulse;
  assign bus.tick      = tick;
  assign bus.sat       = sat;

endmodule

// File: tb/tb_game_tick_timer.sv
// Bench for game_tick_timer: two configurations share one
// stimulus stream and one elapsed-count model.
module tb_game_tick_timer;

  localparam int HZ_A  = 10;
  localparam int MAX_A = 65535;
  localparam int HZ_B  = 4;
  localparam int MAX_B = 7;

  logic        clock;
  logic        reset;
  logic        run;
  logic        pause;
  logic        clear;
  logic [15:0] per;

  int checks = 0;
  int errors = 0;

  game_tick_timer_if #(
    .CNT_W(4), .SEC_W(16), .NUM_TICK(2), .TICK_W(8)
  ) bus_a ();
  game_tick_timer_if #(
    .CNT_W(3), .SEC_W(3), .NUM_TICK(2), .TICK_W(8)
  ) bus_b ();

  assign bus_a.run = run;
  assign bus_a.pause = pause;
  assign bus_a.clear = clear;
  assign bus_a.tick_period = per;
  assign bus_b.run = run;
  assign bus_b.pause = pause;
  assign bus_b.clear = clear;
  assign bus_b.tick_period = per;

  game_tick_timer #(
    .CLK_HZ(HZ_A), .CNT_W(4), .SEC_W(16),
    .NUM_TICK(2), .TICK_W(8)
  ) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (bus_a)
  );

  game_tick_timer #(
    .CLK_HZ(HZ_B), .CNT_W(3), .SEC_W(3),
    .NUM_TICK(2), .TICK_W(8)
  ) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (bus_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model: n counts counting cycles since the last zeroing;
  // c[i] counts counting cycles since channel i last fired.
  longint n;
  bit     counted;
  bit     rq;
  int     c [2];
  bit     tk [2];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      n <= 0;
      counted <= 0;
      rq <= 0;
      for (int i = 0; i < 2; i++) begin
        c[i] <= 0;
        tk[i] <= 0;
      end
    end else begin
      rq <= run;
      if (clear || !run || (run && !rq)) begin
        n <= 0;
        counted <= 0;
        for (int i = 0; i < 2; i++) begin
          c[i] <= 0;
          tk[i] <= 0;
        end
      end else if (pause) begin
        counted <= 0;
        for (int i = 0; i < 2; i++) tk[i] <= 0;
      end else begin
        n <= n + 1;
        counted <= 1;
        for (int i = 0; i < 2; i++) begin
          if (per[i*8 +: 8] == 0) begin
            c[i] <= 0;
            tk[i] <= 0;
          end else if (c[i] + 1 >= int'(per[i*8 +: 8])) begin
            c[i] <= 0;
            tk[i] <= 1;
          end else begin
            c[i] <= c[i] + 1;
            tk[i] <= 0;
          end
        end
      end
    end
  end

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d @%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic longint e_sec(longint hz, longint mx);
    return (n / hz > mx) ? mx : n / hz;
  endfunction

  function automatic longint e_pls(longint hz, longint mx);
    return longint'(counted && n % hz == 0 && n / hz <= mx);
  endfunction

  function automatic longint e_tick();
    return longint'({tk[1], tk[0]});
  endfunction

  always begin
    @(posedge clock);
    #1;
    if (!reset) begin
      chk("a.sub", bus_a.sub_count, n % HZ_A);
      chk("a.sec", bus_a.seconds, e_sec(HZ_A, MAX_A));
      chk("a.pulse", bus_a.sec_pulse, e_pls(HZ_A, MAX_A));
      chk("a.sat", bus_a.sat, longint'(n / HZ_A >= MAX_A));
      chk("a.tick", bus_a.tick, e_tick());
      chk("b.sub", bus_b.sub_count, n % HZ_B);
      chk("b.sec", bus_b.seconds, e_sec(HZ_B, MAX_B));
      chk("b.pulse", bus_b.sec_pulse, e_pls(HZ_B, MAX_B));
      chk("b.sat", bus_b.sat, longint'(n / HZ_B >= MAX_B));
      chk("b.tick", bus_b.tick, e_tick());
    end
  end

  task automatic cyc(int k);
    repeat (k) @(negedge clock);
  endtask

  initial begin
    reset = 1;
    run = 0;
    pause = 0;
    clear = 0;
    per = 16'h0005;
    #1;
    chk("rst.sub", bus_a.sub_count, 0);
    chk("rst.tick", bus_a.tick, 0);
    cyc(2);
    reset = 0;
    cyc(1);
    run = 1;
    cyc(29);
    chk("n28.a.sub", bus_a.sub_count, 8);
    chk("n28.b.sec", bus_b.seconds, 7);
    chk("n28.b.sat", bus_b.sat, 1);
    cyc(2);
    chk("n30.a.sec", bus_a.seconds, 3);
    chk("n30.a.sub", bus_a.sub_count, 0);
    cyc(18);
    chk("n48.b.sec", bus_b.seconds, 7);
    chk("n48.b.pulse", bus_b.sec_pulse, 0);

    clear = 1;
    pause = 1;
    cyc(1);
    clear = 0;
    pause = 0;
    chk("clr.a.sub", bus_a.sub_count, 0);
    chk("clr.b.sat", bus_b.sat, 0);
    cyc(14);
    chk("pre.a.sub", bus_a.sub_count, 4);
    chk("pre.a.sec", bus_a.seconds, 1);
    pause = 1;
    cyc(7);
    chk("hold.a.sub", bus_a.sub_count, 4);
    chk("hold.a.sec", bus_a.seconds, 1);
    pause = 0;
    cyc(5);
    chk("rel5.a.pulse", bus_a.sec_pulse, 0);
    cyc(1);
    chk("rel6.a.pulse", bus_a.sec_pulse, 1);
    chk("rel6.a.sec", bus_a.seconds, 2);

    cyc(3);
    per = 16'h0002;
    cyc(1);
    chk("shrink.t0", bus_a.tick, 1);
    cyc(1);
    chk("p2.gap", bus_a.tick, 0);
    cyc(1);
    chk("p2.fire", bus_a.tick, 1);
    per = 16'h0001;
    cyc(1);
    chk("p1.a", bus_a.tick, 1);
    cyc(1);
    chk("p1.b", bus_a.tick, 1);

    run = 0;
    cyc(1);
    chk("off.a.sub", bus_a.sub_count, 0);
    chk("off.a.sec", bus_a.seconds, 0);
    chk("off.a.tick", bus_a.tick, 0);
    cyc(3);
    run = 1;
    per = 16'h0005;
    cyc(1);
    chk("rise.a.sub", bus_a.sub_count, 0);
    cyc(23);
    chk("n23.a.sec", bus_a.seconds, 2);
    chk("n23.a.sub", bus_a.sub_count, 3);

    #2;
    reset = 1;
    #1;
    chk("arst.a.sub", bus_a.sub_count, 0);
    chk("arst.a.sec", bus_a.seconds, 0);
    chk("arst.a.tick", bus_a.tick, 0);
    chk("arst.b.sat", bus_b.sat, 0);
    @(negedge clock);
    reset = 0;
    cyc(5);
    chk("post.t0.early", bus_a.tick, 0);
    cyc(1);
    chk("post.t0.first", bus_a.tick, 1);
    cyc(12);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
